loopback_link_ctrl: RTL and testbench
=====================================

# loopback_link_ctrl

Bring-up and link-check controller for the native-PHY loopback path. It runs in the 200 MHz fabric domain, which is also the RX FIFO read clock. It sequences the reset-done, delay-ready and VTC handshakes of the TX and RX PHY ports, then drives a training pattern into the TX data input and finds the RX byte alignment. Once aligned, it releases the counter data source and checks the received stream for increment errors.

## Interface
Parameters:
- TRAIN_PATTERN, 8'h0F, training byte. All eight bit-rotations must be distinct.
- MATCH_COUNT, 16, consecutive pattern matches required to lock an offset (1..255).
- FLUSH_CYCLES, 32, cycles spent in TRAIN before alignment starts.
- TIMEOUT, 65535, cycle limit in WAIT_PHY, WAIT_VTC and ALIGN (16-bit counter).
- LOSS_LIMIT, 4, consecutive RUN errors that drop the link.

Ports:
- clk  in  1  200 MHz fabric clock. Single clock; every register is in this domain.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  level. High runs bring-up; low returns to IDLE from any state.
- tx_rst_seq_done, rx_rst_seq_done  in  1 each  PHY reset-sequence done.
- tx_dly_rdy  in  1;  rx_dly_rdy  in  3  delay-ready (RX: bsc2..bsc4).
- tx_vtc_rdy  in  1;  rx_vtc_rdy  in  3  VTC ready.
- en_vtc  out  1  enable VTC to all BSCs.
- source_rst  out  1  active-high reset to the counter data generator.
- gen_data  in  8  counter generator output.
- tx_data  out  8  to data_from_fabric of the TX port.
- fifo_empty  in  2  RX FIFO empty flags (pins 21, 22).
- fifo_rd_en  out  1  RX FIFO read enable.
- fifo_rd_valid  in  1  rx_data valid, one cycle after fifo_rd_en.
- rx_data  in  8  data_to_fabric, P pin.
- aligned_data  out  8;  aligned_valid  out  1  realigned RX stream.
- align_offset  out  3  locked bit offset.
- link_up  out  1;  fail  out  1;  err_count  out  16;  state  out  3.

## Operation
State encoding on `state`: IDLE=0, WAIT_PHY=1, WAIT_VTC=2, TRAIN=3, ALIGN=4, RUN=5, FAIL=6.

Transitions:
- IDLE: when start is high, go to WAIT_PHY and clear the timeout counter.
- WAIT_PHY: when both rst_seq_done and all dly_rdy bits are high, go to WAIT_VTC.
- WAIT_VTC: assert en_vtc. When all four vtc_rdy bits are high, go to TRAIN.
- TRAIN: tx_data = TRAIN_PATTERN and fifo reads run. Clear err_count. After FLUSH_CYCLES, go to ALIGN.
- ALIGN: on each valid byte, form w = {rx_data, prev_byte}. Window k = w[k+7:k].
  - If window[cand] == TRAIN_PATTERN, increment the match count.
  - Otherwise set cand = cand+1 (mod 8) and clear the match count.
  - When the match count reaches MATCH_COUNT, latch align_offset = cand and go to RUN.
- RUN: deassert source_rst; tx_data = gen_data; link_up = 1.
  - Skip TRAIN_PATTERN bytes until the first other byte. That byte seeds the expected value.
  - Each following byte: if it differs from expected+1 (mod 256), increment err_count (saturating at 16'hFFFF) and the consecutive-error count. A correct byte clears the consecutive-error count.
  - Expected value always follows the received byte.
  - When the consecutive-error count reaches LOSS_LIMIT, go to TRAIN.
- Timeout expiry in WAIT_PHY, WAIT_VTC or ALIGN goes to FAIL. The counter clears on every state change.
- FAIL: fail = 1 and is held until start goes low.
- start low in any state goes to IDLE next cycle. This deasserts en_vtc and link_up and asserts source_rst.

Data path rules:
- fifo_rd_en = (state ∈ {TRAIN, ALIGN, RUN}) and fifo_empty == 2'b00.
- tx_data outside RUN is TRAIN_PATTERN.
- aligned_data and aligned_valid are driven in ALIGN and RUN, using the candidate offset in ALIGN and the locked offset in RUN. aligned_valid = 0 otherwise.

## Timing
- Reset values: state=IDLE, en_vtc=0, source_rst=1, tx_data=TRAIN_PATTERN, fifo_rd_en=0, aligned_valid=0, aligned_data=0, align_offset=0, link_up=0, fail=0, err_count=0.
- All outputs are registered except fifo_rd_en and tx_data (combinational from state and inputs).
- Handshake inputs are sampled directly; the PHY syncs them to this domain. A state transition takes effect on the cycle after its condition is seen.
- Alignment latency: aligned_valid follows fifo_rd_valid by 1 cycle.
- err_count updates 1 cycle after the erroneous byte's fifo_rd_valid.
- Returning to TRAIN on loss of lock reasserts source_rst and preserves err_count until TRAIN clears it.

## Test plan
- Done/ready/VTC signals rise at staggered times, start=1 → state reaches TRAIN exactly 1 cycle after the last vtc_rdy rises, en_vtc asserted from WAIT_VTC onward.
- rx_data is the 0x0F stream shifted by 5 bits → align_offset=5 after 16 matches plus candidate misses; link_up=1; aligned_data=0x0F.
- RUN with the RX stream 0,1,2,4,5 → err_count=1, link_up stays 1.
- Four consecutive corrupted bytes → link_up=0, state=TRAIN, source_rst=1, err_count cleared.
- rst_seq_done never rises → fail=1 after 65535 cycles; start=0 → IDLE, fail=0.
- rst_n low mid-RUN → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/loopback_link_ctrl.sv
// Loopback bring-up: PHY handshakes, TX training, RX bit alignment, then counter-stream check.
// Registered outputs land one cycle after their cause; there is no backpressure, so every fifo_rd_valid byte is consumed.
module loopback_link_ctrl #(
   parameter logic [7:0] TRAIN_PATTERN = 8'h0F,
   parameter int         MATCH_COUNT   = 16,
   parameter int         FLUSH_CYCLES  = 32,
   parameter int         TIMEOUT       = 65535,
   parameter int         LOSS_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        tx_rst_seq_done,
   input  logic        rx_rst_seq_done,
   input  logic        tx_dly_rdy,
   input  logic [2:0]  rx_dly_rdy,
   input  logic        tx_vtc_rdy,
   input  logic [2:0]  rx_vtc_rdy,
   output logic        en_vtc,
   output logic        source_rst,
   input  logic [7:0]  gen_data,
   output logic [7:0]  tx_data,
   input  logic [1:0]  fifo_empty,
   output logic        fifo_rd_en,
   input  logic        fifo_rd_valid,
   input  logic [7:0]  rx_data,
   output logic [7:0]  aligned_data,
   output logic        aligned_valid,
   output logic [2:0]  align_offset,
   output logic        link_up,
   output logic        fail,
   output logic [15:0] err_count,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_PHY = 3'd1,
      S_WAIT_VTC = 3'd2,
      S_TRAIN    = 3'd3,
      S_ALIGN    = 3'd4,
      S_RUN      = 3'd5,
      S_FAIL     = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] tmo_q, tmo_d;
   logic [7:0]  prev_q, prev_d;
   logic [2:0]  cand_q, cand_d;
   logic [7:0]  match_q, match_d;
   logic [2:0]  offset_q, offset_d;
   logic        seeded_q, seeded_d;
   logic [7:0]  exp_q, exp_d;
   logic [7:0]  consec_q, consec_d;
   logic [15:0] err_q, err_d;
   logic [7:0]  adata_q, adata_d;
   logic        avalid_q, avalid_d;
   logic        en_vtc_q, en_vtc_d;
   logic        src_rst_q, src_rst_d;
   logic        link_up_q, link_up_d;
   logic        fail_q, fail_d;

   logic [15:0] win16;
   logic [7:0]  win_cand, win_lock;
   logic        phy_ok, vtc_ok, tmo_hit;

   always_comb begin
      win16    = {rx_data, prev_q};
      win_cand = win16[cand_q +: 8];
      win_lock = win16[offset_q +: 8];
      phy_ok   = tx_rst_seq_done & rx_rst_seq_done & tx_dly_rdy & (&rx_dly_rdy);
      vtc_ok   = tx_vtc_rdy & (&rx_vtc_rdy);
      tmo_hit  = (tmo_q == 16'(TIMEOUT - 1));

      state_d  = state_q;
      prev_d   = fifo_rd_valid ? rx_data : prev_q;
      cand_d   = cand_q;
      match_d  = match_q;
      offset_d = offset_q;
      seeded_d = seeded_q;
      exp_d    = exp_q;
      consec_d = consec_q;
      err_d    = err_q;
      adata_d  = adata_q;
      avalid_d = 1'b0;

      case (state_q)
         S_IDLE: if (start) state_d = S_WAIT_PHY;
         S_WAIT_PHY: begin
            if (phy_ok)       state_d = S_WAIT_VTC;
            else if (tmo_hit) state_d = S_FAIL;
         end
         S_WAIT_VTC: begin
            if (vtc_ok)       state_d = S_TRAIN;
            else if (tmo_hit) state_d = S_FAIL;
         end
         S_TRAIN: begin
            err_d    = '0;
            cand_d   = '0;
            match_d  = '0;
            seeded_d = 1'b0;
            consec_d = '0;
            if (tmo_q == 16'(FLUSH_CYCLES - 1)) state_d = S_ALIGN;
         end
         S_ALIGN: begin
            if (fifo_rd_valid) begin
               avalid_d = 1'b1;
               adata_d  = win_cand;
               if (win_cand == TRAIN_PATTERN) begin
                  match_d = match_q + 8'd1;
                  if (match_d == 8'(MATCH_COUNT)) begin
                     offset_d = cand_q;
                     state_d  = S_RUN;
                  end
               end else begin
                  cand_d  = cand_q + 3'd1;
                  match_d = '0;
               end
            end
            if (tmo_hit && state_d == S_ALIGN) state_d = S_FAIL;
         end
         S_RUN: begin
            if (fifo_rd_valid) begin
               avalid_d = 1'b1;
               adata_d  = win_lock;
               exp_d    = win_lock;
               // Training bytes still in flight are ignored until the counter stream shows up.
               if (!seeded_q) begin
                  if (win_lock != TRAIN_PATTERN) seeded_d = 1'b1;
               end else if (win_lock != exp_q + 8'd1) begin
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                  consec_d = consec_q + 8'd1;
                  if (consec_d == 8'(LOSS_LIMIT)) state_d = S_TRAIN;
               end else begin
                  consec_d = '0;
               end
            end
         end
         S_FAIL: state_d = S_FAIL;
         default: state_d = S_IDLE;
      endcase

      if (!start) state_d = S_IDLE;

      tmo_d     = (state_d != state_q) ? 16'd0 : tmo_q + 16'd1;
      en_vtc_d  = (state_d inside {S_WAIT_VTC, S_TRAIN, S_ALIGN, S_RUN});
      src_rst_d = (state_d != S_RUN);
      link_up_d = (state_d == S_RUN);
      fail_d    = (state_d == S_FAIL);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         tmo_q     <= '0;
         prev_q    <= '0;
         cand_q    <= '0;
         match_q   <= '0;
         offset_q  <= '0;
         seeded_q  <= 1'b0;
         exp_q     <= '0;
         consec_q  <= '0;
         err_q     <= '0;
         adata_q   <= '0;
         avalid_q  <= 1'b0;
         en_vtc_q  <= 1'b0;
         src_rst_q <= 1'b1;
         link_up_q <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         prev_q    <= prev_d;
         cand_q    <= cand_d;
         match_q   <= match_d;
         offset_q  <= offset_d;
         seeded_q  <= seeded_d;
         exp_q     <= exp_d;
         consec_q  <= consec_d;
         err_q     <= err_d;
         adata_q   <= adata_d;
         avalid_q  <= avalid_d;
         en_vtc_q  <= en_vtc_d;
         src_rst_q <= src_rst_d;
         link_up_q <= link_up_d;
         fail_q    <= fail_d;
      end
   end

   assign fifo_rd_en    = (state_q inside {S_TRAIN, S_ALIGN, S_RUN}) && (fifo_empty == 2'b00);
   assign tx_data       = (state_q == S_RUN) ? gen_data : TRAIN_PATTERN;
   assign aligned_data  = adata_q;
   assign aligned_valid = avalid_q;
   assign align_offset  = offset_q;
   assign link_up       = link_up_q;
   assign fail          = fail_q;
   assign err_count     = err_q;
   assign en_vtc        = en_vtc_q;
   assign source_rst    = src_rst_q;
   assign state         = state_q;

endmodule

// File: tb/tb_loopback_link_ctrl.sv
// Directed bench for loopback_link_ctrl: bring-up, alignment at offset 5, RUN error counting, loss of lock, reset, timeout.
module tb_loopback_link_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic        tx_rst_seq_done, rx_rst_seq_done, tx_dly_rdy, tx_vtc_rdy;
   logic [2:0]  rx_dly_rdy, rx_vtc_rdy;
   logic        en_vtc, source_rst;
   logic [7:0]  gen_data, tx_data;
   logic [1:0]  fifo_empty;
   logic        fifo_rd_en, fifo_rd_valid;
   logic [7:0]  rx_data, aligned_data;
   logic        aligned_valid, link_up, fail;
   logic [2:0]  align_offset, state;
   logic [15:0] err_count;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] last_a;

   always #5 clk = ~clk;

   loopback_link_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .tx_rst_seq_done(tx_rst_seq_done), .rx_rst_seq_done(rx_rst_seq_done),
      .tx_dly_rdy(tx_dly_rdy), .rx_dly_rdy(rx_dly_rdy),
      .tx_vtc_rdy(tx_vtc_rdy), .rx_vtc_rdy(rx_vtc_rdy),
      .en_vtc(en_vtc), .source_rst(source_rst),
      .gen_data(gen_data), .tx_data(tx_data),
      .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_valid(fifo_rd_valid),
      .rx_data(rx_data), .aligned_data(aligned_data), .aligned_valid(aligned_valid),
      .align_offset(align_offset), .link_up(link_up), .fail(fail),
      .err_count(err_count), .state(state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The RX byte carrying aligned byte a_i at offset 5 is {a_(i+1)[2:0], a_i[7:3]},
   // so each push emits the byte for the previously pushed value.
   task automatic push(input logic [7:0] a);
      rx_data       = {a[2:0], last_a[7:3]};
      fifo_rd_valid = 1'b1;
      last_a        = a;
      tick();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"},  32'(state), 32'd0);
      check({tag, "_envtc"},  32'(en_vtc), 32'd0);
      check({tag, "_srcrst"}, 32'(source_rst), 32'd1);
      check({tag, "_txdata"}, 32'(tx_data), 32'h0F);
      check({tag, "_rden"},   32'(fifo_rd_en), 32'd0);
      check({tag, "_avld"},   32'(aligned_valid), 32'd0);
      check({tag, "_adat"},   32'(aligned_data), 32'd0);
      check({tag, "_offs"},   32'(align_offset), 32'd0);
      check({tag, "_link"},   32'(link_up), 32'd0);
      check({tag, "_fail"},   32'(fail), 32'd0);
      check({tag, "_err"},    32'(err_count), 32'd0);
   endtask

   logic [7:0] run_seq  [6] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6};
   logic [7:0] loss_seq [5] = '{8'd7, 8'h20, 8'h40, 8'h60, 8'h80};

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0;
      tx_rst_seq_done = 1'b0; rx_rst_seq_done = 1'b0; tx_dly_rdy = 1'b0; rx_dly_rdy = 3'b000;
      tx_vtc_rdy = 1'b0; rx_vtc_rdy = 3'b000;
      gen_data = 8'hA5; fifo_empty = 2'b11; fifo_rd_valid = 1'b0; rx_data = 8'h00;
      last_a = 8'h0F;
      tick(); tick();
      check_reset_values("rst");

      // Staggered bring-up
      rst_n = 1'b1; start = 1'b1;
      tick();
      check("wait_phy", 32'(state), 32'd1);
      check("wait_phy_envtc", 32'(en_vtc), 32'd0);
      tx_rst_seq_done = 1'b1; tick(); tick();
      rx_rst_seq_done = 1'b1; tick();
      tx_dly_rdy = 1'b1; tick();
      rx_dly_rdy = 3'b011; tick();
      check("phy_partial", 32'(state), 32'd1);
      rx_dly_rdy = 3'b111; tick();
      check("wait_vtc", 32'(state), 32'd2);
      check("wait_vtc_envtc", 32'(en_vtc), 32'd1);
      tx_vtc_rdy = 1'b1; tick();
      rx_vtc_rdy = 3'b001; tick();
      rx_vtc_rdy = 3'b101; tick();
      check("vtc_partial", 32'(state), 32'd2);
      rx_vtc_rdy = 3'b111; tick();
      check("train_entry", 32'(state), 32'd3);
      check("train_envtc", 32'(en_vtc), 32'd1);
      check("train_txdata", 32'(tx_data), 32'h0F);
      fifo_empty = 2'b01; #1;
      check("rden_empty", 32'(fifo_rd_en), 32'd0);
      fifo_empty = 2'b00; #1;
      check("rden_train", 32'(fifo_rd_en), 32'd1);

      // Training stream shifted by 5 bits: 32 flush cycles, 5 misses, 16 matches
      n = 0;
      while (state != 3'd5 && n < 300) begin
         push(8'h0F);
         n++;
      end
      check("lock_state", 32'(state), 32'd5);
      check("lock_cycles", 32'(n), 32'd53);
      check("lock_offset", 32'(align_offset), 32'd5);
      check("lock_link", 32'(link_up), 32'd1);
      check("lock_srcrst", 32'(source_rst), 32'd0);
      #1;
      check("run_txdata", 32'(tx_data), 32'hA5);
      push(8'h0F);
      check("run_avld", 32'(aligned_valid), 32'd1);
      check("run_adat", 32'(aligned_data), 32'h0F);

      // Counter stream 0,1,2,4,5 (6 flushes the last byte through)
      for (int i = 0; i < 6; i++) push(run_seq[i]);
      check("run_err", 32'(err_count), 32'd1);
      check("run_link", 32'(link_up), 32'd1);
      check("run_state", 32'(state), 32'd5);
      check("run_adat5", 32'(aligned_data), 32'd5);

      // Four consecutive bad bytes drop the link
      for (int i = 0; i < 5; i++) push(loss_seq[i]);
      check("pre_loss_state", 32'(state), 32'd5);
      check("pre_loss_err", 32'(err_count), 32'd4);
      push(8'h90);
      check("loss_state", 32'(state), 32'd3);
      check("loss_link", 32'(link_up), 32'd0);
      check("loss_srcrst", 32'(source_rst), 32'd1);
      check("loss_err_kept", 32'(err_count), 32'd5);
      push(8'h0F);
      check("train_err_clr", 32'(err_count), 32'd0);

      n = 0;
      while (state != 3'd5 && n < 300) begin
         push(8'h0F);
         n++;
      end
      check("relock_state", 32'(state), 32'd5);
      check("relock_offset", 32'(align_offset), 32'd5);

      // Reset in the middle of RUN
      rst_n = 1'b0; fifo_rd_valid = 1'b0;
      tick();
      check_reset_values("midrun");

      // PHY never finishes reset: timeout
      tx_rst_seq_done = 1'b0; rx_rst_seq_done = 1'b0; tx_dly_rdy = 1'b0; rx_dly_rdy = 3'b000;
      tx_vtc_rdy = 1'b0; rx_vtc_rdy = 3'b000;
      rst_n = 1'b1; start = 1'b1;
      tick();
      check("tmo_wait_phy", 32'(state), 32'd1);
      n = 0;
      while (!fail && n < 70000) begin
         tick();
         n++;
      end
      check("tmo_cycles", 32'(n), 32'd65535);
      check("tmo_state", 32'(state), 32'd6);
      tick();
      check("fail_held", 32'(fail), 32'd1);
      start = 1'b0;
      tick();
      check("stop_state", 32'(state), 32'd0);
      check("stop_fail", 32'(fail), 32'd0);
      check("stop_srcrst", 32'(source_rst), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
